reset_seq: RTL and testbench

Parametrised clock-domain reset sequencer sitting directly behind the PLL. It watches the PLL lock, holds every downstream domain in reset until lock is stable, then stretches reset and releases NUM_CH reset channels in a staggered ascending order. A filtered lock-loss detector and a software reset request re-enter the sequence, and a saturating counter records lock-loss events.

---
 rtl/reset_seq.sv | 163 ++++++++++++++++
 tb/tb_reset_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// reset_seq: PLL-lock driven reset sequencer with staggered channel release.
// Optional lock-loss event counter enabled by defining RESET_SEQ_LOSS_COUNT_EN. Rev 1.0
`default_nettype none

module reset_seq #(
  parameter int NUM_CH      = 4,
  parameter int STRETCH     = 16,
  parameter int STAGGER     = 8,
  parameter int LOCK_FILTER = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk_in,
  input  logic              resetb_in,
  input  logic              lock_in,
  input  logic              sw_reset_req,
  output logic [NUM_CH-1:0] reset_out,
  output logic              all_released,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  lock_loss_count
);

  localparam int TMAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(NUM_CH) + 1;
  localparam int FW   = $clog2(LOCK_FILTER + 1);

  localparam logic [TW-1:0] STRETCH_LAST = TW'(STRETCH - 1);
  localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER - 1);
  localparam logic [FW-1:0] FILT_LAST    = FW'(LOCK_FILTER - 1);
  localparam logic [IW-1:0] CH_LAST      = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STRETCH   = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [IW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              rel_q, rel_d;
  logic              sync1_q, lock_s_q;
  logic              loss_w;

  // lock_in is asynchronous to clk_in
  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= lock_in;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in) begin
      state_q <= S_WAIT_LOCK;
      timer_q <= '0;
      filt_q  <= '0;
      ch_q    <= '0;
      rst_q   <= '1;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      filt_q  <= filt_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    filt_d  = '0;
    ch_d    = ch_q;
    rst_d   = rst_q;
    loss_w  = 1'b0;

    if (state_q != S_WAIT_LOCK && !lock_s_q) begin
      if (filt_q == FILT_LAST) loss_w = 1'b1;
      else                     filt_d = filt_q + 1'b1;
    end

    // Lock loss takes priority over a coincident software request
    if (loss_w) begin
      state_d = S_WAIT_LOCK;
      rst_d   = '1;
      timer_d = '0;
      ch_d    = '0;
    end else if (sw_reset_req && state_q != S_WAIT_LOCK) begin
      state_d = S_STRETCH;
      rst_d   = '1;
      timer_d = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          rst_d   = '1;
          timer_d = '0;
          ch_d    = '0;
          if (lock_s_q) state_d = S_STRETCH;
        end
        S_STRETCH: begin
          if (timer_q == STRETCH_LAST) begin
            timer_d  = '0;
            rst_d[0] = 1'b0;
            ch_d     = IW'(1);
            state_d  = (NUM_CH == 1) ? S_RUN : S_RELEASE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (timer_q == STAGGER_LAST) begin
            timer_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
              if (IW'(k) == ch_q) rst_d[k] = 1'b0;
            end
            ch_d = ch_q + 1'b1;
            if (ch_q == CH_LAST) state_d = S_RUN;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_RUN: begin
          rst_d = '0;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          rst_d   = '1;
        end
      endcase
    end

    rel_d = (state_d == S_RUN);
  end

`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in)                cnt_q <= '0;
    else if (loss_w && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign lock_loss_count = cnt_q;
`else
  assign lock_loss_count = '0;
`endif

  assign reset_out    = rst_q;
  assign all_released = rel_q;
  assign state_out    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed checks of reset_seq (defaults) and a small NUM_CH=1, CNT_W=2 instance.
`default_nettype none

module tb_reset_seq;

`ifdef RESET_SEQ_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, lock, sw;
  logic [3:0] rout;
  logic       allrel;
  logic [1:0] st;
  logic [7:0] cnt;

  logic       rst2_n, lock2, sw2;
  logic [0:0] rout2;
  logic       allrel2;
  logic [1:0] st2;
  logic [1:0] cnt2;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_seq u_dut (
    .clk_in(clk), .resetb_in(rst_n), .lock_in(lock), .sw_reset_req(sw),
    .reset_out(rout), .all_released(allrel), .state_out(st), .lock_loss_count(cnt)
  );

  reset_seq #(.NUM_CH(1), .STRETCH(2), .STAGGER(1), .LOCK_FILTER(2), .CNT_W(2)) u_dut2 (
    .clk_in(clk), .resetb_in(rst2_n), .lock_in(lock2), .sw_reset_req(sw2),
    .reset_out(rout2), .all_released(allrel2), .state_out(st2), .lock_loss_count(cnt2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance to 1 time unit after the given rising edge
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  int b, r, t;
  int exp2;

  initial begin
    rst_n = 1'b1; lock = 1'b0; sw = 1'b0;
    rst2_n = 1'b1; lock2 = 1'b0; sw2 = 1'b0;
    #2 rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    check_val("rst_reset_out", rout, 4'hF);
    check_val("rst_all_rel", allrel, 0);
    check_val("rst_state", st, 0);
    check_val("rst_count", cnt, 0);
    goto(3);
    rst_n = 1'b1; rst2_n = 1'b1;
    goto(5);
    check_val("wait_no_lock", rout, 4'hF);

    b = cyc;
    lock = 1'b1;
    goto(b + 2);  check_val("pre_stretch_state", st, 0);
    goto(b + 3);  check_val("stretch_state", st, 1);
    goto(b + 18); check_val("ch0_hold", rout, 4'hF);
    goto(b + 19); check_val("ch0_rel", rout, 4'hE);
                  check_val("release_state", st, 2);
    goto(b + 27); check_val("ch1_rel", rout, 4'hC);
    goto(b + 35); check_val("ch2_rel", rout, 4'h8);
    goto(b + 42); check_val("pre_run_allrel", allrel, 0);
    goto(b + 43); check_val("ch3_rel", rout, 4'h0);
                  check_val("run_allrel", allrel, 1);
                  check_val("run_state", st, 3);

    goto(b + 50); lock = 1'b0;
    goto(b + 52); lock = 1'b1;
    goto(b + 60); check_val("glitch_rout", rout, 4'h0);
                  check_val("glitch_state", st, 3);
                  check_val("glitch_count", cnt, 0);

    goto(b + 100); lock = 1'b0;
    goto(b + 105); check_val("loss_pre", rout, 4'h0);
    goto(b + 106); check_val("loss_rout", rout, 4'hF);
                   check_val("loss_state", st, 0);
                   check_val("loss_allrel", allrel, 0);
                   check_val("loss_count", cnt, CNT_EN ? 1 : 0);
    lock = 1'b1;
    goto(b + 149); check_val("relock_run", st, 3);

    goto(b + 199); sw = 1'b1;
    goto(b + 200); sw = 1'b0;
                   check_val("sw_rout", rout, 4'hF);
                   check_val("sw_state", st, 1);
    goto(b + 215); check_val("sw_ch0_hold", rout, 4'hF);
    goto(b + 216); check_val("sw_ch0", rout, 4'hE);
    goto(b + 224); check_val("sw_ch1", rout, 4'hC);
    goto(b + 232); check_val("sw_ch2", rout, 4'h8);
    goto(b + 240); check_val("sw_ch3", rout, 4'h0);
                   check_val("sw_run", st, 3);

    goto(b + 299); sw = 1'b1;
    goto(b + 300); sw = 1'b0;
    goto(b + 324); check_val("mid_rel_rout", rout, 4'hC);
                   check_val("mid_rel_state", st, 2);
    #3 rst_n = 1'b0;
    #1;
    check_val("async_rout", rout, 4'hF);
    check_val("async_allrel", allrel, 0);
    check_val("async_state", st, 0);
    check_val("async_count", cnt, 0);
    goto(b + 326); rst_n = 1'b1;
    r = cyc;
    goto(r + 18); check_val("replay_hold", rout, 4'hF);
    goto(r + 19); check_val("replay_ch0", rout, 4'hE);
    goto(r + 43); check_val("replay_done", rout, 4'h0);
                  check_val("replay_state", st, 3);

    for (int i = 0; i < 5; i++) begin
      lock2 = 1'b1;
      t = cyc;
      goto(t + 4); check_val("d2_hold", rout2, 1);
      goto(t + 5); check_val("d2_rel", rout2, 0);
                   check_val("d2_run", st2, 3);
                   check_val("d2_allrel", allrel2, 1);
      lock2 = 1'b0;
      t = cyc;
      goto(t + 3); check_val("d2_loss_pre", rout2, 0);
      goto(t + 4); check_val("d2_loss_rout", rout2, 1);
                   check_val("d2_loss_state", st2, 0);
      exp2 = CNT_EN ? ((i + 1 > 3) ? 3 : i + 1) : 0;
      check_val("d2_count", cnt2, exp2);
    end

    lock2 = 1'b1;
    t = cyc;
    goto(t + 5); check_val("d2_coinc_run", st2, 3);
    lock2 = 1'b0;
    t = cyc;
    goto(t + 3); sw2 = 1'b1;
    goto(t + 4); sw2 = 1'b0;
                 check_val("coinc_state", st2, 0);
                 check_val("coinc_rout", rout2, 1);
                 check_val("coinc_count", cnt2, CNT_EN ? 3 : 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
